// File: rtl/axi_rd_dma_pkg.sv
// Shared types and AXI constants for the AXI read DMA.
// Also provides a constant log2 helper that turns the beat width into arsize.
package axi_rd_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_ARPROT     = 3'b010;
  localparam int unsigned BOUNDARY_4K    = 4096;

  // Ceiling log2; exact for the power-of-two widths used here.
  function automatic int log2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// Synchronous FIFO with occupancy count; read data is visible the cycle after the write.
// Writes are dropped when full and pops are ignored when empty, so the owner must gate both.
module axi_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr];

  // Storage carries no reset; flushing is done by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_dma.sv
// AXI4 read master streaming LENGTH beats from ADDR into AXI-Stream, bursts split at 4 KB.
// AXIS data lags its R beat by one cycle; ARs are only issued when the FIFO can absorb the whole burst.
module axi_rd_dma
  import axi_rd_dma_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [31:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arregion,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    START_REG,
  input  logic [31:0]             ADDR_REG,
  input  logic [31:0]             LENGTH_REG,
  output logic                    RIDLE_REG,
  output logic [31:0]             CYCLES_REG,
  output logic                    RERR_REG
);

  localparam int BEAT_SHIFT = log2(DATA_WIDTH / 8);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [31:0] remain_q;
  logic [31:0] total_q;
  logic [31:0] outstanding_q;
  logic [31:0] recv_q;
  logic [31:0] sent_q;
  logic [31:0] cycles_q;
  logic        rerr_q;
  logic        arvalid_q;
  logic [31:0] beats_to_4k;
  logic [31:0] burst_len;
  logic        ar_issue_ok;
  logic        ar_hs;
  logic        r_hs;
  logic        axis_hs;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic        unused_ok;

  // rid and rlast carry no information here; framing comes from the beat count.
  assign unused_ok = ^{m_axi_rid, m_axi_rlast, m_axi_rresp[0]};

  // Burst size only depends on addr_q/remain_q, which move solely on AR handshake,
  // so araddr/arlen stay stable while arvalid waits.
  always_comb begin
    beats_to_4k = (32'(BOUNDARY_4K) - {20'd0, addr_q[11:0]}) >> BEAT_SHIFT;
    burst_len   = remain_q;
    if (burst_len > 32'(MAX_BURST)) burst_len = 32'(MAX_BURST);
    if (burst_len > beats_to_4k)    burst_len = beats_to_4k;
  end

  assign ar_issue_ok = (state == ADDR) && !arvalid_q && (remain_q != '0) &&
                       (32'(fifo_count) + outstanding_q + burst_len <= 32'(FIFO_DEPTH));
  assign ar_hs   = arvalid_q && m_axi_arready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;
  assign axis_hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START_REG) state_nxt = LOAD;
      LOAD:    state_nxt = ADDR;
      ADDR:    if (remain_q == '0) state_nxt = DATA;
      DATA:    if (recv_q == total_q) state_nxt = DONE;
      DONE:    if (!START_REG) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q        <= '0;
      remain_q      <= '0;
      total_q       <= '0;
      outstanding_q <= '0;
      recv_q        <= '0;
      sent_q        <= '0;
      cycles_q      <= '0;
      rerr_q        <= 1'b0;
      arvalid_q     <= 1'b0;
    end else if (state == LOAD) begin
      addr_q        <= ADDR_REG;
      remain_q      <= LENGTH_REG;
      total_q       <= LENGTH_REG;
      outstanding_q <= '0;
      recv_q        <= '0;
      sent_q        <= '0;
      cycles_q      <= '0;
      rerr_q        <= 1'b0;
      arvalid_q     <= 1'b0;
    end else begin
      if (ar_hs) begin
        addr_q    <= addr_q + (burst_len << BEAT_SHIFT);
        remain_q  <= remain_q - burst_len;
        arvalid_q <= 1'b0;
      end else if (ar_issue_ok) begin
        arvalid_q <= 1'b1;
      end
      case ({ar_hs, r_hs})
        2'b10:   outstanding_q <= outstanding_q + burst_len;
        2'b01:   outstanding_q <= outstanding_q - 32'd1;
        2'b11:   outstanding_q <= outstanding_q + burst_len - 32'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (r_hs)    recv_q <= recv_q + 32'd1;
      if (axis_hs) sent_q <= sent_q + 32'd1;
      if (state == ADDR || state == DATA) cycles_q <= cycles_q + 32'd1;
      if (r_hs && m_axi_rresp[1]) rerr_q <= 1'b1;
    end
  end

  axi_rd_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .wr_vld (r_hs),
    .wr_dat (m_axi_rdata),
    .rd_rdy (axis_hs),
    .rd_dat (m_axis_tdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'(burst_len - 32'd1);
  assign m_axi_arsize   = 3'(BEAT_SHIFT);
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'd0;
  assign m_axi_arprot   = AXI_ARPROT;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = !fifo_full;
  assign m_axis_tvalid  = !fifo_empty;
  assign m_axis_tstrb   = '1;
  assign m_axis_tlast   = m_axis_tvalid && (sent_q + 32'd1 == total_q);
  assign RIDLE_REG      = (state == IDLE);
  assign CYCLES_REG     = cycles_q;
  assign RERR_REG       = rerr_q;

endmodule

// File: tb/tb_axi_rd_dma.sv
// Bench for axi_rd_dma: randomised AXI slave and AXIS sink, checked against a
// burst-splitting reference model and per-address data pattern.
module tb_axi_rd_dma;

  logic        clk = 1'b0;
  logic        rstn;
  logic [0:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arregion;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [0:0]  m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        START_REG;
  logic [31:0] ADDR_REG;
  logic [31:0] LENGTH_REG;
  logic        RIDLE_REG;
  logic [31:0] CYCLES_REG;
  logic        RERR_REG;

  always #5 clk = ~clk;

  axi_rd_dma #(.ID_WIDTH(1), .DATA_WIDTH(64), .MAX_BURST(16), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rstn(rstn),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arregion(m_axi_arregion),
    .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .START_REG(START_REG), .ADDR_REG(ADDR_REG), .LENGTH_REG(LENGTH_REG),
    .RIDLE_REG(RIDLE_REG), .CYCLES_REG(CYCLES_REG), .RERR_REG(RERR_REG)
  );

  int checks = 0;
  int failures = 0;

  // Written by the test sequence, read by the slave/sink process.
  int          arready_mode = 0;   // 0 random, 1 held low
  int          tready_mode  = 0;   // 0 always ready, 1 random, 2 held low
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          ar_base;
  int          ax_base;

  // Written only by the slave/sink process.
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [63:0] ax_dat_log[$];
  logic        ax_last_log[$];
  logic [31:0] pend_addr[$];
  logic        pend_last[$];
  int unread = 0, max_unread = 0, stall_cycles = 0, arvalid_cycles = 0, tvalid_cycles = 0;

  // Reference model outputs.
  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [63:0] exp_dat[$];

  function automatic logic [63:0] dat_of(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Bursts: min(remaining, 16, beats to next 4 KB); each beat is 8 bytes.
  task automatic build_model(input logic [31:0] a, input int len);
    logic [31:0] cur;
    int rem, room, b;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_dat.delete();
    for (int i = 0; i < len; i++) exp_dat.push_back(dat_of(a + 32'(i * 8)));
    cur = a;
    rem = len;
    while (rem > 0) begin
      room = (4096 - int'(cur % 32'd4096)) / 8;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_ar_addr.push_back(cur);
      exp_ar_len.push_back(8'(b - 1));
      cur = cur + 32'(b * 8);
      rem = rem - b;
    end
  endtask

  // AXI read slave, AXIS sink and observers: sample at negedge, drive just after posedge.
  initial begin
    bit r_took;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rid = '0; m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      r_took = 1'b0;
      if (!rstn) begin
        pend_addr.delete(); pend_last.delete(); unread = 0;
      end else begin
        if (m_axi_arvalid) arvalid_cycles++;
        if (m_axis_tvalid) tvalid_cycles++;
        if (m_axi_rvalid && !m_axi_rready) stall_cycles++;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_addr_log.push_back(m_axi_araddr);
          ar_len_log.push_back(m_axi_arlen);
          for (int k = 0; k <= int'(m_axi_arlen); k++) begin
            pend_addr.push_back(m_axi_araddr + 32'(k * 8));
            pend_last.push_back(k == int'(m_axi_arlen));
          end
          unread += int'(m_axi_arlen) + 1;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          void'(pend_addr.pop_front());
          void'(pend_last.pop_front());
          r_took = 1'b1;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          ax_dat_log.push_back(m_axis_tdata);
          ax_last_log.push_back(m_axis_tlast);
          unread--;
        end
        if (unread > max_unread) max_unread = unread;
      end
      @(posedge clk);
      #1;
      if (!rstn || r_took) m_axi_rvalid = 1'b0;
      if (!m_axi_rvalid && pend_addr.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = dat_of(pend_addr[0]);
        m_axi_rlast  = pend_last[0];
        m_axi_rresp  = (err_en && pend_addr[0] == err_addr) ? 2'b10 : 2'b00;
      end
      m_axi_arready = (arready_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic start_transfer(input logic [31:0] a, input int len, input int tmode);
    ar_base = ar_addr_log.size();
    ax_base = ax_dat_log.size();
    tready_mode = tmode;
    ADDR_REG = a;
    LENGTH_REG = 32'(len);
    START_REG = 1'b1;
    build_model(a, len);
  endtask

  task automatic wait_beats(input int len, output bit ok);
    int t = 0;
    while ((ax_dat_log.size() - ax_base) < len && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    ok = (t < 5000);
  endtask

  task automatic end_transfer(output bit ok);
    int t = 0;
    START_REG = 1'b0;
    while (RIDLE_REG !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    ok = (RIDLE_REG === 1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (RIDLE_REG !== 1'b1) begin failures++; $display("FAIL reset_ridle got=%b exp=1", RIDLE_REG); end
    checks++; if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", m_axi_arvalid); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (CYCLES_REG !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", CYCLES_REG); end
    checks++; if (RERR_REG !== 1'b0) begin failures++; $display("FAIL reset_rerr got=%b exp=0", RERR_REG); end
    checks++; if (m_axi_rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%b exp=1", m_axi_rready); end
    checks++;
    if (m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01 || m_axi_arprot !== 3'b010 || m_axis_tstrb !== 8'hFF) begin
      failures++;
      $display("FAIL ar_constants got size=%0d burst=%0d prot=%0d strb=%h exp 3/1/2/ff",
               m_axi_arsize, m_axi_arburst, m_axi_arprot, m_axis_tstrb);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    bit ok;
    start_transfer(32'h0000_1000, 16, 0);
    wait_beats(16, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d beats exp=16", ax_dat_log.size() - ax_base); end
    checks++;
    if (ar_addr_log.size() - ar_base != 1) begin
      failures++; $display("FAIL single_ar_count got=%0d exp=1", ar_addr_log.size() - ar_base);
    end else if (ar_addr_log[ar_base] !== 32'h1000 || ar_len_log[ar_base] !== 8'd15) begin
      failures++; $display("FAIL single_ar got=%h/%0d exp=1000/15", ar_addr_log[ar_base], ar_len_log[ar_base]);
    end
    if (ax_dat_log.size() - ax_base >= 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (ax_dat_log[ax_base+i] !== exp_dat[i] || ax_last_log[ax_base+i] !== (i == 15)) begin
          failures++;
          $display("FAIL single_beat%0d got=%h/%b exp=%h/%b", i, ax_dat_log[ax_base+i], ax_last_log[ax_base+i], exp_dat[i], i == 15);
        end
      end
    end
    checks++; if (RIDLE_REG !== 1'b0) begin failures++; $display("FAIL single_done_busy got=%b exp=0", RIDLE_REG); end
    checks++; if (CYCLES_REG < 32'd16) begin failures++; $display("FAIL single_cycles got=%0d exp>=16", CYCLES_REG); end
    end_transfer(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle got=%b exp=1", RIDLE_REG); end
  endtask

  task automatic test_4k_split();
    bit ok;
    logic [31:0] ea[3];
    logic [7:0]  el[3];
    ea[0] = 32'h0FC0; ea[1] = 32'h1000; ea[2] = 32'h1080;
    el[0] = 8'd7;     el[1] = 8'd15;    el[2] = 8'd7;
    start_transfer(32'h0000_0FC0, 32, 1);
    wait_beats(32, ok);
    checks++; if (!ok) begin failures++; $display("FAIL split_timeout got=%0d beats exp=32", ax_dat_log.size() - ax_base); end
    checks++;
    if (ar_addr_log.size() - ar_base != 3) begin
      failures++; $display("FAIL split_ar_count got=%0d exp=3", ar_addr_log.size() - ar_base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ar_addr_log[ar_base+i] !== ea[i] || ar_len_log[ar_base+i] !== el[i]) begin
          failures++; $display("FAIL split_ar%0d got=%h/%0d exp=%h/%0d", i, ar_addr_log[ar_base+i], ar_len_log[ar_base+i], ea[i], el[i]);
        end
      end
    end
    if (ax_dat_log.size() - ax_base >= 32) begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (ax_dat_log[ax_base+i] !== exp_dat[i] || ax_last_log[ax_base+i] !== (i == 31)) begin
          failures++;
          $display("FAIL split_beat%0d got=%h/%b exp=%h/%b", i, ax_dat_log[ax_base+i], ax_last_log[ax_base+i], exp_dat[i], i == 31);
        end
      end
    end
    end_transfer(ok);
    checks++; if (!ok) begin failures++; $display("FAIL split_idle got=%b exp=1", RIDLE_REG); end
  endtask

  task automatic test_zero_len();
    bit ok;
    int arv0, tv0;
    arv0 = arvalid_cycles;
    tv0  = tvalid_cycles;
    start_transfer(32'h0000_5000, 0, 0);
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (arvalid_cycles != arv0) begin failures++; $display("FAIL zero_arvalid got=%0d cycles exp=0", arvalid_cycles - arv0); end
    checks++; if (tvalid_cycles != tv0) begin failures++; $display("FAIL zero_tvalid got=%0d cycles exp=0", tvalid_cycles - tv0); end
    checks++; if (CYCLES_REG !== 32'd2) begin failures++; $display("FAIL zero_cycles got=%0d exp=2", CYCLES_REG); end
    end_transfer(ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_done got=%b exp=1", RIDLE_REG); end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_transfer(32'h0002_0000, 200, 2);
    repeat (500) begin @(posedge clk); #1; end
    checks++; if (ax_dat_log.size() != ax_base) begin failures++; $display("FAIL bp_early_pop got=%0d exp=0", ax_dat_log.size() - ax_base); end
    checks++; if (unread != 64) begin failures++; $display("FAIL bp_fill got=%0d exp=64", unread); end
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%b exp=1", m_axis_tvalid); end
    tready_mode = 0;
    wait_beats(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d beats exp=200", ax_dat_log.size() - ax_base); end
    checks++; if (max_unread > 64) begin failures++; $display("FAIL bp_credit got=%0d exp<=64", max_unread); end
    checks++; if (stall_cycles != 0) begin failures++; $display("FAIL bp_rready got=%0d stalled cycles exp=0", stall_cycles); end
    checks++;
    if (ar_addr_log.size() - ar_base != exp_ar_addr.size()) begin
      failures++; $display("FAIL bp_ar_count got=%0d exp=%0d", ar_addr_log.size() - ar_base, exp_ar_addr.size());
    end
    if (ax_dat_log.size() - ax_base >= 200) begin
      for (int i = 0; i < 200; i++) begin
        checks++;
        if (ax_dat_log[ax_base+i] !== exp_dat[i] || ax_last_log[ax_base+i] !== (i == 199)) begin
          failures++;
          $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, ax_dat_log[ax_base+i], ax_last_log[ax_base+i], exp_dat[i], i == 199);
        end
      end
    end
    end_transfer(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_idle got=%b exp=1", RIDLE_REG); end
  endtask

  task automatic test_rresp_error();
    bit ok;
    int t;
    err_addr = 32'h0000_3000 + 32'd32;
    err_en = 1'b1;
    start_transfer(32'h0000_3000, 16, 0);
    wait_beats(16, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rerr_timeout got=%0d beats exp=16", ax_dat_log.size() - ax_base); end
    checks++; if (RERR_REG !== 1'b1) begin failures++; $display("FAIL rerr_set got=%b exp=1", RERR_REG); end
    end_transfer(ok);
    checks++; if (RERR_REG !== 1'b1 || !ok) begin failures++; $display("FAIL rerr_sticky got=%b idle=%b exp=1/1", RERR_REG, RIDLE_REG); end
    err_en = 1'b0;
    start_transfer(32'h0000_4000, 8, 0);
    t = 0;
    while (RIDLE_REG !== 1'b0 && t < 20) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (RERR_REG !== 1'b0) begin failures++; $display("FAIL rerr_clear got=%b exp=0", RERR_REG); end
    wait_beats(8, ok);
    end_transfer(ok);
    checks++; if (!ok || RERR_REG !== 1'b0) begin failures++; $display("FAIL rerr_clean got=%b idle=%b exp=0/1", RERR_REG, RIDLE_REG); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    arready_mode = 1;
    start_transfer(32'h0000_6000, 32, 0);
    while (m_axi_arvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    checks++; if (m_axi_arvalid !== 1'b1) begin failures++; $display("FAIL mid_arvalid_wait got=%b exp=1", m_axi_arvalid); end
    rstn = 1'b0;
    START_REG = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || RIDLE_REG !== 1'b1 || m_axis_tvalid !== 1'b0 || CYCLES_REG !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset got arvalid=%b ridle=%b tvalid=%b cycles=%0d exp 0/1/0/0",
               m_axi_arvalid, RIDLE_REG, m_axis_tvalid, CYCLES_REG);
    end
    rstn = 1'b1;
    arready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] a;
    int len;
    for (int n = 0; n < 6; n++) begin
      a   = (n == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFF8);
      len = (n == 0) ? 20 : int'($urandom_range(1, 100));
      start_transfer(a, len, 1);
      wait_beats(len, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout got=%0d beats exp=%0d", n, ax_dat_log.size() - ax_base, len); end
      checks++;
      if (ar_addr_log.size() - ar_base != exp_ar_addr.size()) begin
        failures++; $display("FAIL rnd%0d_ar_count got=%0d exp=%0d", n, ar_addr_log.size() - ar_base, exp_ar_addr.size());
      end else begin
        for (int i = 0; i < exp_ar_addr.size(); i++) begin
          checks++;
          if (ar_addr_log[ar_base+i] !== exp_ar_addr[i] || ar_len_log[ar_base+i] !== exp_ar_len[i]) begin
            failures++;
            $display("FAIL rnd%0d_ar%0d got=%h/%0d exp=%h/%0d", n, i, ar_addr_log[ar_base+i], ar_len_log[ar_base+i], exp_ar_addr[i], exp_ar_len[i]);
          end
        end
      end
      if (ax_dat_log.size() - ax_base >= len) begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (ax_dat_log[ax_base+i] !== exp_dat[i] || ax_last_log[ax_base+i] !== (i == len - 1)) begin
            failures++;
            $display("FAIL rnd%0d_beat%0d got=%h/%b exp=%h/%b", n, i, ax_dat_log[ax_base+i], ax_last_log[ax_base+i], exp_dat[i], i == len - 1);
          end
        end
      end
      end_transfer(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_idle got=%b exp=1", n, RIDLE_REG); end
    end
    checks++; if (stall_cycles != 0) begin failures++; $display("FAIL rnd_rready got=%0d stalled cycles exp=0", stall_cycles); end
  endtask

  initial begin
    rstn = 1'b0;
    START_REG = 1'b0;
    ADDR_REG = '0;
    LENGTH_REG = '0;
    test_reset();
    test_single_burst();
    test_4k_split();
    test_zero_len();
    test_backpressure();
    test_rresp_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_dma.md
AXI_RD_DMA -- requirements
Module: axi_rd_dma

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, width of AXI ID fields.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI/AXIS data width in bits; legal values are powers of 2 from 8 to 1024.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per AR burst; legal values are powers of 2 from 1 to 256.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, data FIFO depth in beats; legal values are powers of 2 with FIFO_DEPTH >= MAX_BURST.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rstn, input, 1 bit, reset; synchronous, active-low.
REQ-007 SHALL have port m_axi_araddr, output, 32 bits, burst start address.
REQ-008 SHALL have port m_axi_arlen, output, 8 bits, beats minus 1.
REQ-009 SHALL drive m_axi_arid/arsize/arburst/arlock/arcache/arprot/arregion/arqos (ID_WIDTH/3/2/1/4/3/4/4 bits) as constants: 0, log2(DATA_WIDTH/8), INCR, 0, 0, 3'b010, 0, 0.
REQ-010 SHALL have port m_axi_arvalid, output, 1 bit, and m_axi_arready, input, 1 bit.
REQ-011 SHALL have port m_axi_rid, input, ID_WIDTH bits, ignored.
REQ-012 SHALL have port m_axi_rdata, input, DATA_WIDTH bits.
REQ-013 SHALL have port m_axi_rresp, input, 2 bits, response code.
REQ-014 SHALL have ports m_axi_rlast and m_axi_rvalid, inputs, 1 bit each, and m_axi_rready, output, 1 bit.
REQ-015 SHALL have port m_axis_tvalid, output, 1 bit, and m_axis_tready, input, 1 bit.
REQ-016 SHALL have port m_axis_tdata, output, DATA_WIDTH bits, and m_axis_tstrb, output, DATA_WIDTH/8 bits, tied to all ones.
REQ-017 SHALL have port m_axis_tlast, output, 1 bit, marking the final beat of the transfer.
REQ-018 SHALL have ports START_REG (input, 1), ADDR_REG (input, 32, byte address aligned to DATA_WIDTH/8) and LENGTH_REG (input, 32, total beats).
REQ-019 SHALL have outputs RIDLE_REG (1 bit, idle flag), CYCLES_REG (32 bits, transfer duration) and RERR_REG (1 bit, sticky error).

Function
REQ-020 FSM SHALL have states IDLE, LOAD, ADDR, DATA and DONE. IDLE->LOAD when START_REG=1. LOAD->ADDR always. ADDR->DATA when the remaining AR beat count reaches 0. DATA->DONE when all LENGTH beats have been accepted on R. DONE->IDLE when START_REG=0.
REQ-021 LOAD SHALL latch ADDR_REG and LENGTH_REG, clear CYCLES_REG and RERR_REG, and zero the credit counters. If LENGTH_REG=0, ADDR and DATA SHALL pass through with no AR issued.
REQ-022 Burst length SHALL be min(remaining beats, MAX_BURST, beats left to the next 4 KB boundary), so that no burst crosses 4 KB.
REQ-023 In ADDR, arvalid SHALL assert only when the FIFO free space, minus beats already requested but not yet received, is at least the burst length.
REQ-024 Once asserted, arvalid SHALL hold with stable araddr/arlen until arready.
REQ-025 On each AR handshake the address SHALL advance by len*DATA_WIDTH/8 and the remaining count SHALL drop by len. An AR handshake and an R beat in the same cycle SHALL update the outstanding count by +len-1.
REQ-026 m_axi_rready SHALL equal ~fifo_full; the credit rule guarantees it never deasserts. R beats are written in arrival order.
REQ-027 m_axis_tvalid SHALL equal ~fifo_empty; a beat is popped on tvalid&tready; first-word latency is 1 cycle from the R handshake.
REQ-028 m_axis_tlast SHALL be 1 only on the beat numbered LENGTH. rlast on R SHALL NOT be used for AXIS framing.
REQ-029 CYCLES_REG SHALL increment every cycle in ADDR and DATA, and hold its value otherwise.
REQ-030 RERR_REG SHALL set on any accepted R beat with rresp[1]=1 and hold until the next LOAD.
REQ-031 RIDLE_REG SHALL be 1 only in IDLE. START_REG changes outside IDLE/DONE SHALL be ignored.
REQ-032 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-033 While rstn=0 at a clk edge: state IDLE, arvalid 0, FIFO flushed (tvalid 0), CYCLES_REG 0, RERR_REG 0, all counters 0. This SHALL hold even mid-burst; R beats still in flight after reset are the system's responsibility.

Structure
REQ-034 Package axi_rd_dma_pkg SHALL hold state_t, the AXI constants (INCR, ARPROT value, 4 KB boundary) and a log2 function used for arsize.
REQ-035 One sub-module, axi_rd_fifo, SHALL implement the synchronous FIFO (DATA_WIDTH x FIFO_DEPTH) with full, empty and occupancy-count outputs.

Verification
REQ-036 ADDR=0x1000, LENGTH=16, DW=64, MAX_BURST=16 -> one AR (0x1000, arlen=15); 16 AXIS beats with tlast on beat 16; RIDLE returns to 1 after START drops.
REQ-037 ADDR=0x0FC0, LENGTH=32 -> AR sequence (0x0FC0, len 7), (0x1000, len 15), (0x1080, len 7).
REQ-038 LENGTH=0 -> no arvalid, DONE reached, tvalid never asserts.
REQ-039 FIFO_DEPTH=64, LENGTH=200, tready=0 for 500 cycles -> requested-but-unread beats never exceed 64; rready never 0; after release, 200 beats arrive in order.
REQ-040 rresp=2'b10 on beat 5 -> RERR_REG=1 at DONE, and 0 after the next LOAD.
REQ-041 rstn=0 during an arvalid wait -> next cycle arvalid=0, RIDLE=1, tvalid=0.
